// File: rtl/gray_pkg.sv
// Shared Gray-code definitions: default widths, tracker states, WIDTH-generic Gray->binary helper.
// gray2bin is combinational; callers zero-extend into GRAY_MAX_W and truncate the result.
package gray_pkg;

    localparam int GRAY_W_DEF      = 4;
    localparam int REV_W_DEF       = 8;
    localparam int ERR_W_DEF       = 4;
    localparam int SYNC_STAGES_DEF = 2;
    localparam int GRAY_MAX_W      = 32;

    typedef enum logic {
        PRIME = 1'b0,
        TRACK = 1'b1
    } trk_state_e;

    // Running XOR from the MSB down; zero-extended upper bits leave the accumulator at 0.
    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
        logic                  acc;
        logic [GRAY_MAX_W-1:0] b;
        acc = 1'b0;
        b   = '0;
        for (int i = GRAY_MAX_W - 1; i >= 0; i--) begin
            acc  = acc ^ g[i];
            b[i] = acc;
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_sync.sv
// Multi-bit SYNC_STAGES-deep synchroniser for a Gray word; latency SYNC_STAGES cycles.
// vld_o rises once the pipeline holds only post-reset samples; no backpressure.
module gray_sync #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o,
    output logic             vld_o
);

    logic [WIDTH-1:0]       stage_q [SYNC_STAGES];
    logic [SYNC_STAGES-1:0] fill_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                stage_q[i] <= '0;
            end
            fill_q <= '0;
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
            fill_q <= {fill_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign q_o   = stage_q[SYNC_STAGES-1];
    assign vld_o = fill_q[SYNC_STAGES-1];

endmodule

// File: rtl/gray_position_decoder.sv
// Synchronise and decode a Gray position; track step direction, revolutions and illegal jumps.
// Latency SYNC_STAGES+1 (SYNC_STAGES+2 with GRAY_DEGLITCH_EN); no backpressure.
module gray_position_decoder
    import gray_pkg::*;
#(
    parameter int WIDTH       = GRAY_W_DEF,
    parameter int REV_W       = REV_W_DEF,
    parameter int ERR_W       = ERR_W_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic [WIDTH-1:0] gray_in,
    output logic [WIDTH-1:0] pos_bin,
    output logic             pos_valid,
    output logic             step_pulse,
    output logic             dir_up,
    output logic [REV_W-1:0] rev_count,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count
);

    localparam logic [WIDTH-1:0] POS_MAX  = '1;
    localparam logic [WIDTH-1:0] DIFF_UP  = WIDTH'(1);
    localparam logic [WIDTH-1:0] DIFF_DN  = '1;
    localparam logic [ERR_W-1:0] ERR_MAX  = '1;

    logic [WIDTH-1:0] sync_gray;
    logic             sync_vld;
    logic [WIDTH-1:0] new_bin;
    logic [WIDTH-1:0] diff_d;
    logic             accept;

    trk_state_e       state_q;
    logic [WIDTH-1:0] pos_q;
    logic             valid_q;
    logic             step_q;
    logic             dir_q;
    logic [REV_W-1:0] rev_q;
    logic             err_q;
    logic [ERR_W-1:0] err_cnt_q;

    gray_sync #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (gray_in),
        .q_o   (sync_gray),
        .vld_o (sync_vld)
    );

    assign new_bin = WIDTH'(gray2bin(GRAY_MAX_W'(sync_gray)));
    assign diff_d  = new_bin - pos_q;

`ifdef GRAY_DEGLITCH_EN
    // A value must be seen on two consecutive synchronised cycles before it is evaluated.
    logic [WIDTH-1:0] prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= '0;
        end else begin
            prev_q <= sync_gray;
        end
    end

    assign accept = sync_vld && (sync_gray == prev_q);
`else
    assign accept = sync_vld;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= PRIME;
            pos_q     <= '0;
            valid_q   <= 1'b0;
            step_q    <= 1'b0;
            dir_q     <= 1'b0;
            rev_q     <= '0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else if (clear) begin
            state_q   <= PRIME;
            valid_q   <= 1'b0;
            step_q    <= 1'b0;
            rev_q     <= '0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            step_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                PRIME: begin
                    if (accept) begin
                        pos_q   <= new_bin;
                        valid_q <= 1'b1;
                        state_q <= TRACK;
                    end
                end
                TRACK: begin
                    // Legality is decided by the binary difference only, not the Gray bit count.
                    if (accept && diff_d != '0) begin
                        pos_q <= new_bin;
                        if (diff_d == DIFF_UP) begin
                            step_q <= 1'b1;
                            dir_q  <= 1'b1;
                            if (pos_q == POS_MAX) rev_q <= rev_q + REV_W'(1);
                        end else if (diff_d == DIFF_DN) begin
                            step_q <= 1'b1;
                            dir_q  <= 1'b0;
                            if (pos_q == '0) rev_q <= rev_q - REV_W'(1);
                        end else begin
                            err_q <= 1'b1;
                            if (err_cnt_q != ERR_MAX) err_cnt_q <= err_cnt_q + ERR_W'(1);
                        end
                    end
                end
                default: state_q <= PRIME;
            endcase
        end
    end

    assign pos_bin    = pos_q;
    assign pos_valid  = valid_q;
    assign step_pulse = step_q;
    assign dir_up     = dir_q;
    assign rev_count  = rev_q;
    assign err_pulse  = err_q;
    assign err_count  = err_cnt_q;

endmodule

// File: tb/tb_gray_position_decoder.sv
// Directed bench for gray_position_decoder: expectations queued at drive time, popped at output time.
module tb_gray_position_decoder;

`ifdef GRAY_DEGLITCH_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 3;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clear = 1'b0;
    logic [3:0] gray_in = 4'b0;
    logic [3:0] pos_bin;
    logic       pos_valid;
    logic       step_pulse;
    logic       dir_up;
    logic [7:0] rev_count;
    logic       err_pulse;
    logic [3:0] err_count;

    gray_position_decoder #(
        .WIDTH       (4),
        .REV_W       (8),
        .ERR_W       (4),
        .SYNC_STAGES (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .gray_in    (gray_in),
        .pos_bin    (pos_bin),
        .pos_valid  (pos_valid),
        .step_pulse (step_pulse),
        .dir_up     (dir_up),
        .rev_count  (rev_count),
        .err_pulse  (err_pulse),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] pos;
        logic       valid;
        logic       step;
        logic       dir;
        logic [7:0] rev;
        logic       err;
        logic [3:0] ecnt;
    } exp_t;

    exp_t sb[$];

    logic [3:0] m_pos;
    logic       m_valid;
    logic       m_dir;
    logic [7:0] m_rev;
    logic [3:0] m_ecnt;
    bit         m_primed;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] bin2gray(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic exp_t snap(input logic step, input logic err);
        exp_t e;
        e.pos   = m_pos;
        e.valid = m_valid;
        e.step  = step;
        e.dir   = m_dir;
        e.rev   = m_rev;
        e.err   = err;
        e.ecnt  = m_ecnt;
        return e;
    endfunction

    task automatic model_reset();
        m_pos = 4'd0; m_valid = 1'b0; m_dir = 1'b0;
        m_rev = 8'd0; m_ecnt = 4'd0; m_primed = 1'b0;
    endtask

    task automatic model_sample(input logic [3:0] nb);
        logic [3:0] d;
        logic       st;
        logic       er;
        st = 1'b0;
        er = 1'b0;
        if (!m_primed) begin
            m_primed = 1'b1;
            m_valid  = 1'b1;
            m_pos    = nb;
        end else begin
            d = nb - m_pos;
            if (d == 4'd1) begin
                st = 1'b1; m_dir = 1'b1;
                if (m_pos == 4'd15) m_rev = m_rev + 8'd1;
            end else if (d == 4'd15) begin
                st = 1'b1; m_dir = 1'b0;
                if (m_pos == 4'd0) m_rev = m_rev - 8'd1;
            end else if (d != 4'd0) begin
                er = 1'b1;
                if (m_ecnt != 4'd15) m_ecnt = m_ecnt + 4'd1;
            end
            m_pos = nb;
        end
        sb.push_back(snap(st, er));
    endtask

    task automatic check_out(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $error("FAIL %s: observed empty scoreboard expected an entry", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, ".pos"},   32'(pos_bin),    32'(e.pos));
            chk({tag, ".valid"}, 32'(pos_valid),  32'(e.valid));
            chk({tag, ".step"},  32'(step_pulse), 32'(e.step));
            chk({tag, ".dir"},   32'(dir_up),     32'(e.dir));
            chk({tag, ".rev"},   32'(rev_count),  32'(e.rev));
            chk({tag, ".err"},   32'(err_pulse),  32'(e.err));
            chk({tag, ".ecnt"},  32'(err_count),  32'(e.ecnt));
        end
    endtask

    task automatic step_to(input logic [3:0] b, input string tag);
        @(negedge clk);
        gray_in = bin2gray(b);
        model_sample(b);
        repeat (LAT) @(posedge clk);
        @(negedge clk);
        check_out(tag);
        @(negedge clk);
        chk({tag, ".step_off"}, 32'(step_pulse), 32'(0));
        chk({tag, ".err_off"},  32'(err_pulse),  32'(0));
    endtask

    initial begin
        model_reset();
        gray_in = 4'b0110;
        repeat (2) @(negedge clk);
        sb.push_back(snap(1'b0, 1'b0));
        check_out("reset");

        rst_n = 1'b1;
        model_sample(4'd4);
        repeat (LAT) @(posedge clk);
        @(negedge clk);
        check_out("prime");

        for (int b = 3; b >= 0; b--) step_to(4'(b), "down_to0");
        for (int b = 1; b <= 15; b++) step_to(4'(b), "sweep_up");
        step_to(4'd0, "wrap_up");
        step_to(4'd15, "wrap_dn");
        step_to(4'd14, "rev_14");

        step_to(4'd1, "jump_a");
        step_to(4'd14, "jump_b");
        for (int i = 0; i < 20; i++) step_to((i % 2 == 0) ? 4'd1 : 4'd14, "jump_sat");

        // clear lands on the same edge that would have reported the 14->15 step
        @(negedge clk);
        gray_in = bin2gray(4'd15);
        repeat (LAT - 1) @(posedge clk);
        @(negedge clk);
        clear = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clear = 1'b0;
        m_rev = 8'd0; m_ecnt = 4'd0; m_valid = 1'b0; m_primed = 1'b0;
        sb.push_back(snap(1'b0, 1'b0));
        check_out("clear");
        model_sample(4'd15);
        @(posedge clk);
        @(negedge clk);
        check_out("reprime");

        step_to(4'd0, "post_clear_wrap");

        @(negedge clk);
        rst_n = 1'b0;
        gray_in = 4'b0000;
        model_reset();
        sb.push_back(snap(1'b0, 1'b0));
        @(negedge clk);
        check_out("midrst");
        rst_n = 1'b1;
        model_sample(4'd0);
        for (int k = 0; k < LAT; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk("midrst_exit.step", 32'(step_pulse), 32'(0));
            chk("midrst_exit.err",  32'(err_pulse),  32'(0));
        end
        check_out("midrst_prime");

`ifdef GRAY_DEGLITCH_EN
        @(negedge clk);
        gray_in = 4'b0001;
        @(negedge clk);
        gray_in = 4'b0000;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("glitch.pos",  32'(pos_bin),    32'(0));
            chk("glitch.step", 32'(step_pulse), 32'(0));
            chk("glitch.err",  32'(err_pulse),  32'(0));
        end
`endif
        step_to(4'd1, "stable_step");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/gray_position_decoder.md
Name: gray_position_decoder

Overview:
- Receive-side partner of the binary-to-Gray encoder.
- Accepts a Gray-coded absolute position word from an external encoder or another block, synchronises it and decodes it to binary.
- Tracks motion: step direction, revolution count across wrap-around, and illegal multi-step jumps.
- Sits between the external Gray source and the control logic that consumes binary position.

Parameters:
- WIDTH, 4, Gray/binary position width in bits (>=2).
- REV_W, 8, revolution counter width (two's complement, signed).
- ERR_W, 4, illegal-jump counter width (saturating).
- SYNC_STAGES, 2, input synchroniser flop count (>=2).

Ports:
- clk  input  1  system clock; all flops on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- clear  input  1  synchronous clear of tracking state, active-high.
- gray_in  input  WIDTH  Gray-coded position, asynchronous to clk.
- pos_bin  output  WIDTH  decoded binary position, registered.
- pos_valid  output  1  high once a first sample has been taken after reset or clear.
- step_pulse  output  1  one-cycle pulse on a legal +/-1 position change.
- dir_up  output  1  direction of the last legal step: 1 = increment, 0 = decrement.
- rev_count  output  REV_W  signed revolution count.
- err_pulse  output  1  one-cycle pulse on an illegal jump.
- err_count  output  ERR_W  saturating count of illegal jumps.

Behaviour:
- Reset (rst_n low, asynchronous): every synchroniser flop, pos_bin, pos_valid, step_pulse, dir_up, rev_count, err_pulse and err_count go to 0.
- Synchroniser: gray_in passes through SYNC_STAGES flops, giving sync_gray.
- Decode (combinational on sync_gray):
  - bin[WIDTH-1] = g[WIDTH-1].
  - bin[i] = bin[i+1] ^ g[i] for i from WIDTH-2 down to 0.
- Latency: a change on gray_in appears on pos_bin SYNC_STAGES+1 cycles later; pulses are aligned with that pos_bin update.
- Tracker states: PRIME and TRACK.
- PRIME (after reset or clear):
  - Next cycle: pos_bin <= decoded value, pos_valid <= 1, go to TRACK.
  - No step or error is reported on the priming sample.
- TRACK, each cycle: d = new_bin - pos_bin, modulo 2^WIDTH.
  - d == 0: hold; no pulses.
  - d == 1: step_pulse=1, dir_up=1, pos_bin updated.
    - If pos_bin was 2^WIDTH-1 and new is 0: rev_count += 1 (wraps modulo 2^REV_W).
  - d == 2^WIDTH-1: step_pulse=1, dir_up=0, pos_bin updated.
    - If pos_bin was 0 and new is 2^WIDTH-1: rev_count -= 1 (wraps).
  - Any other d: err_pulse=1, err_count += 1 (saturates at 2^ERR_W-1), pos_bin resyncs to the new value.
    - rev_count and dir_up are unchanged; no step_pulse.
  - A single Gray bit change is not sufficient for legality. Only the binary difference decides.
- step_pulse and err_pulse are mutually exclusive and never high more than one cycle per event.
- clear:
  - Zeroes rev_count, err_count, pos_valid, step_pulse and err_pulse, then enters PRIME.
  - pos_bin and dir_up hold their values.
  - clear wins over a simultaneous step or error; that sample is not counted.
  - The synchroniser is not cleared.
- Mid-operation reset: all state returns to reset values immediately, with no pulse on exit from reset.

Optional Feature:
- Macro: GRAY_DEGLITCH_EN.
- Defined:
  - A new decoded value is accepted only after it is identical on 2 consecutive synchronised cycles.
  - Latency becomes SYNC_STAGES+2.
  - A value present for a single cycle is ignored and produces no pulse and no count.
  - The priming sample also requires 2 stable cycles.
- Undefined: every synchronised value is evaluated immediately, as specified above.

Decomposition:
- Package gray_pkg:
  - Default width constants.
  - A gray2bin function (WIDTH-generic, loop form), shared with the encoder testbenches.
  - The tracker state enum {PRIME, TRACK}.
- One natural sub-module, gray_sync: SYNC_STAGES-deep multi-bit synchroniser with async active-low reset.
- Decode, compare and counters stay in the top module.

Test Plan (WIDTH=4, REV_W=8, ERR_W=4, SYNC_STAGES=2, macro undefined unless stated):
- Reset then gray_in=0110 held -> after 3 cycles pos_bin=0100, pos_valid=1, no pulses, rev_count=0.
- Sweep binary 0..15 as Gray codes, one per 4 cycles, then 15->0 -> 16 step_pulse with dir_up=1; rev_count=1 after the 1000->0000 transition; err_count=0.
- Reverse sweep 0->15->14 -> first step dir_up=0, rev_count decrements 1->0, pos_bin=1110 at end.
- Jump Gray 0001 (bin 1) -> 1001 (bin 14) -> err_pulse once, err_count=1, pos_bin=1110, rev_count unchanged; 20 illegal jumps -> err_count saturates at 15.
- clear asserted in the same cycle as a legal step -> no step_pulse, rev_count=0, err_count=0, pos_valid=0, then re-primes to the current value with no pulse.
- GRAY_DEGLITCH_EN defined, 1-cycle glitch 0000->0001->0000 -> no pulse, pos_bin stays 0000; stable 0001 for 2 cycles -> one step_pulse, dir_up=1.
